// File: rtl/tz_table_arbiter_if.sv
// Request, shared-table and result signals between the total_zeros arbiter and its neighbours.
// slave: arbiter side; master: requesters, table and packer side.
interface tz_table_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int CODE_W = 7
);
  logic              req0_valid;
  logic              req0_ready;
  logic [4:0]        req0_tc;
  logic [3:0]        req0_tz;
  logic              req1_valid;
  logic              req1_ready;
  logic [4:0]        req1_tc;
  logic [3:0]        req1_tz;
  logic [ADDR_W-1:0] tab_addr;
  logic [CODE_W-1:0] tab_code;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_id;
  logic              out_skip;
  logic              out_err;

  modport slave (
    input  req0_valid, req0_tc, req0_tz,
    input  req1_valid, req1_tc, req1_tz,
    input  tab_code, out_ready,
    output req0_ready, req1_ready, tab_addr,
    output out_valid, out_code, out_id, out_skip, out_err
  );

  modport master (
    output req0_valid, req0_tc, req0_tz,
    output req1_valid, req1_tc, req1_tz,
    output tab_code, out_ready,
    input  req0_ready, req1_ready, tab_addr,
    input  out_valid, out_code, out_id, out_skip, out_err
  );
endinterface

// File: rtl/tz_table_arbiter.sv
// Round-robin sharing of one total_zeros VLC table between two CAVLC encoders; skips tc==0/MAX lookups.
// TZ_SYNC_TAB_EN: registered table, adds a WAIT cycle before LOOKUP (lookup latency 3 instead of 2).
module tz_table_arbiter #(
  parameter int MAX_COEFF = 16,
  parameter int ADDR_W    = 8,
  parameter int CODE_W    = 7
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  tz_table_arbiter_if.slave   io_bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;
`ifdef TZ_SYNC_TAB_EN
  localparam logic [1:0] ST_WAIT   = 2'd3;
`endif
  localparam logic [5:0] MAXC      = 6'(MAX_COEFF);

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_tab_addr;
  logic [CODE_W-1:0] r_out_code;
  logic              r_out_id;
  logic              r_out_skip;
  logic              r_out_err;

  logic       w_grant0;
  logic       w_grant1;
  logic       w_acc;
  logic       w_id;
  logic [4:0] w_tc;
  logic [3:0] w_tz;
  logic [5:0] w_tc_ext;
  logic [5:0] w_room;
  logic       w_skip;
  logic       w_err;

  // Under contention the requester that did not win last time is served.
  assign w_grant0 = io_bus.req0_valid & (~io_bus.req1_valid | r_last_grant);
  assign w_grant1 = io_bus.req1_valid & (~io_bus.req0_valid | ~r_last_grant);
  assign w_acc    = (r_state == ST_IDLE) & (w_grant0 | w_grant1);
  assign w_id     = w_grant1;

  assign w_tc     = w_id ? io_bus.req1_tc : io_bus.req0_tc;
  assign w_tz     = w_id ? io_bus.req1_tz : io_bus.req0_tz;
  assign w_tc_ext = {1'b0, w_tc};
  assign w_room   = MAXC - w_tc_ext;
  assign w_skip   = (w_tc_ext == 6'd0) | (w_tc_ext == MAXC);
  assign w_err    = (w_tc_ext > MAXC) | (~w_skip & ({2'b00, w_tz} > w_room));

  assign io_bus.req0_ready = (r_state == ST_IDLE) & w_grant0;
  assign io_bus.req1_ready = (r_state == ST_IDLE) & w_grant1;
  assign io_bus.tab_addr   = r_tab_addr;
  assign io_bus.out_valid  = (r_state == ST_OUT);
  assign io_bus.out_code   = r_out_code;
  assign io_bus.out_id     = r_out_id;
  assign io_bus.out_skip   = r_out_skip;
  assign io_bus.out_err    = r_out_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_tab_addr   <= '0;
      r_out_code   <= '0;
      r_out_id     <= 1'b0;
      r_out_skip   <= 1'b0;
      r_out_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_last_grant <= w_id;
            r_out_id     <= w_id;
            r_out_skip   <= w_skip;
            r_out_err    <= w_err;
            r_out_code   <= '0;
            // Skipped and illegal blocks never touch the table, so tab_addr keeps its old value.
            if (w_skip | w_err) begin
              r_state <= ST_OUT;
            end else begin
              r_tab_addr <= ADDR_W'({w_tc[3:0], w_tz});
`ifdef TZ_SYNC_TAB_EN
              r_state    <= ST_WAIT;
`else
              r_state    <= ST_LOOKUP;
`endif
            end
          end
        end
`ifdef TZ_SYNC_TAB_EN
        ST_WAIT: r_state <= ST_LOOKUP;
`endif
        ST_LOOKUP: begin
          r_out_code <= io_bus.tab_code;
          r_state    <= ST_OUT;
        end
        ST_OUT: begin
          if (io_bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tz_table_arbiter.sv
// Directed bench for tz_table_arbiter: vector table of single requests plus contention, backpressure and reset sequences.
module tb_tz_table_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tz_table_arbiter_if bus ();

  tz_table_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  function automatic logic [6:0] tab_model(input logic [7:0] a);
    return 7'(a * 8'd3 + 8'd5);
  endfunction

  assign bus.tab_code = tab_model(bus.tab_addr);

`ifdef TZ_SYNC_TAB_EN
  localparam int LOOKUP_LAT = 3;
  localparam int LOOKUP_IVL = 4;
`else
  localparam int LOOKUP_LAT = 2;
  localparam int LOOKUP_IVL = 3;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] prev_addr = 8'h00;

  typedef struct {
    bit         id;
    logic [4:0] tc;
    logic [3:0] tz;
    bit         skip;
    bit         err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic drop_valids();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic do_req(input bit id, input logic [4:0] tc, input logic [3:0] tz,
                        input bit eskip, input bit eerr, input string nm);
    bit         granted;
    int         lat;
    int         exp_lat;
    logic [7:0] eaddr;
    logic [6:0] ecode;
    granted = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    if (id) begin
      bus.req1_valid = 1'b1; bus.req1_tc = tc; bus.req1_tz = tz;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_tc = tc; bus.req0_tz = tz;
    end
    for (int i = 0; i < 10 && !granted; i++) begin
      #1;
      if (id ? bus.req1_ready : bus.req0_ready) granted = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_grant"}, 32'(granted), 32'd1);
    if (!granted) begin
      drop_valids();
      return;
    end
    chk({nm, "_other_rdy"}, 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
    @(posedge clk);
    #1;
    drop_valids();
    eaddr   = (eskip | eerr) ? prev_addr : {tc[3:0], tz};
    ecode   = (eskip | eerr) ? 7'd0 : tab_model(eaddr);
    exp_lat = (eskip | eerr) ? 1 : LOOKUP_LAT;
    for (lat = 1; lat <= 10; lat++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_addr"}, 32'(bus.tab_addr), 32'(eaddr));
    chk({nm, "_code"}, 32'(bus.out_code), 32'(ecode));
    chk({nm, "_id"}, 32'(bus.out_id), 32'(id));
    chk({nm, "_skip"}, 32'(bus.out_skip), 32'(eskip));
    chk({nm, "_err"}, 32'(bus.out_err), 32'(eerr));
    prev_addr = eaddr;
    @(posedge clk);
    #1;
    chk({nm, "_done"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = 8'h00;
  endtask

  initial begin
    int grants[$];
    int gtime[$];
    int ids[$];
    bit got;

    vecs[0] = '{id: 1'b0, tc: 5'd1,  tz: 4'd3,  skip: 1'b0, err: 1'b0};
    vecs[1] = '{id: 1'b1, tc: 5'd0,  tz: 4'd0,  skip: 1'b1, err: 1'b0};
    vecs[2] = '{id: 1'b1, tc: 5'd16, tz: 4'd0,  skip: 1'b1, err: 1'b0};
    vecs[3] = '{id: 1'b0, tc: 5'd14, tz: 4'd5,  skip: 1'b0, err: 1'b1};
    vecs[4] = '{id: 1'b0, tc: 5'd14, tz: 4'd2,  skip: 1'b0, err: 1'b0};
    vecs[5] = '{id: 1'b1, tc: 5'd17, tz: 4'd0,  skip: 1'b0, err: 1'b1};
    vecs[6] = '{id: 1'b0, tc: 5'd15, tz: 4'd1,  skip: 1'b0, err: 1'b0};
    vecs[7] = '{id: 1'b1, tc: 5'd16, tz: 4'd3,  skip: 1'b1, err: 1'b0};
    vecs[8] = '{id: 1'b1, tc: 5'd3,  tz: 4'd13, skip: 1'b0, err: 1'b0};
    vecs[9] = '{id: 1'b0, tc: 5'd3,  tz: 4'd14, skip: 1'b0, err: 1'b1};

    bus.req0_valid = 1'b0; bus.req0_tc = '0; bus.req0_tz = '0;
    bus.req1_valid = 1'b0; bus.req1_tc = '0; bus.req1_tz = '0;
    bus.out_ready  = 1'b1;

    #12;
    chk("rst_addr",  32'(bus.tab_addr),  32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_code",  32'(bus.out_code),  32'd0);
    chk("rst_flags", 32'({bus.out_id, bus.out_skip, bus.out_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++)
      do_req(vecs[v].id, vecs[v].tc, vecs[v].tz, vecs[v].skip, vecs[v].err, $sformatf("vec%0d", v));

    // Contention: both requesters held valid, grants must alternate starting with requester 0.
    reset_pulse();
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_tc = 5'd2; bus.req0_tz = 4'd1;
    bus.req1_valid = 1'b1; bus.req1_tc = 5'd2; bus.req1_tz = 4'd1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) chk("cont_both_rdy", 32'd1, 32'd0);
      if (bus.req0_ready) begin grants.push_back(0); gtime.push_back(cyc); end
      if (bus.req1_ready) begin grants.push_back(1); gtime.push_back(cyc); end
      if (bus.out_valid) ids.push_back(int'(bus.out_id));
      @(negedge clk);
    end
    drop_valids();
    chk("cont_ngrants", 32'(grants.size() >= 4), 32'd1);
    chk("cont_nids", 32'(ids.size() >= 4), 32'd1);
    if (grants.size() >= 4 && ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cont_grant%0d", i), 32'(grants[i]), 32'(i % 2));
        chk($sformatf("cont_id%0d", i), 32'(ids[i]), 32'(i % 2));
        if (i > 0) chk($sformatf("cont_ivl%0d", i), 32'(gtime[i] - gtime[i-1]), 32'(LOOKUP_IVL));
      end
    end
    repeat (4) @(negedge clk);
    prev_addr = 8'h21;

    // Backpressure: result held for 5 cycles while both requesters wait.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_tc = 5'd1; bus.req0_tz = 4'd3;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (bus.req0_ready) got = 1'b1; else @(negedge clk);
    end
    chk("bp_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b1; bus.req1_tc = 5'd2; bus.req1_tz = 4'd1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    chk("bp_valid_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_payload%0d", i),
          32'({bus.out_code, bus.out_id, bus.out_skip, bus.out_err}),
          32'({tab_model(8'h13), 3'b000}));
      chk($sformatf("bp_rdy%0d", i), 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    end
    drop_valids();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(bus.out_valid), 32'd0);
    prev_addr = 8'h13;

    // Reset while the table lookup is in flight.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_tc = 5'd1; bus.req0_tz = 4'd4;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (bus.req0_ready) got = 1'b1; else @(negedge clk);
    end
    chk("rl_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    drop_valids();
    chk("rl_pre_addr", 32'(bus.tab_addr), 32'h14);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rl_addr",  32'(bus.tab_addr),  32'd0);
    chk("rl_valid", 32'(bus.out_valid), 32'd0);
    chk("rl_payload", 32'({bus.out_code, bus.out_id, bus.out_skip, bus.out_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_addr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rl_no_out%0d", i), 32'(bus.out_valid), 32'd0);
    end
    do_req(1'b1, 5'd2, 4'd1, 1'b0, 1'b0, "rl_req1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tz_table_arbiter.md
Name: tz_table_arbiter

Overview:
- Shares one combinational total_zeros VLC table (8-bit address in, 7-bit code out) between two CAVLC block encoders, for example the luma and chroma-AC lanes.
- Arbitrates round-robin between the two requesters and forms the table address.
- Suppresses lookups that the H.264 rules skip (TotalCoeff == 0 or TotalCoeff == MAX_COEFF).
- Returns the code tagged with the requester ID over a valid/ready interface to the bitstream packer.

Parameters:
- MAX_COEFF, 16: maxNumCoeff of the blocks served (16 for 4x4, 15 for AC). Sets the skip and error rules.
- ADDR_W, 8: table address width. Address is {total_coeff[3:0], total_zeros[3:0]}.
- CODE_W, 7: table code width. The code is treated as opaque and passed through unchanged.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a block.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req0_tc  in  5  requester 0 TotalCoeff, 0..16.
- req0_tz  in  4  requester 0 total_zeros.
- req1_valid, req1_ready, req1_tc, req1_tz  same as requester 0, for requester 1.
- tab_addr  out  ADDR_W  address to the shared table.
- tab_code  in  CODE_W  table output, combinational from tab_addr.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_code  out  CODE_W  registered table code.
- out_id  out  1  requester that owns the result.
- out_skip  out  1  no total_zeros is coded for this block; out_code = 0.
- out_err  out  1  illegal input (tz > MAX_COEFF - tc, or tc > MAX_COEFF).

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - tab_addr = 0; out_valid, out_code, out_id, out_skip, out_err all = 0.
  - Reset mid-transaction drops any in-flight result with no output.
- FSM states: IDLE, LOOKUP, OUT.
- IDLE:
  - If only one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant.
  - reqN_ready = (state == IDLE) & grantN, combinational. Ready is never asserted to a requester that is not valid.
- On the accept edge:
  - Latch tc, tz and id; update last_grant.
  - Compute skip = (tc == 0) | (tc == MAX_COEFF).
  - Compute err = (tc > MAX_COEFF) | (!skip & (tz > MAX_COEFF - tc)).
  - If skip or err: go straight to OUT with out_code = 0. tab_addr is unchanged (no table access).
  - Otherwise: tab_addr <= {tc[3:0], tz}; go to LOOKUP.
- LOOKUP (one cycle): out_code <= tab_code at the edge; go to OUT.
- OUT:
  - out_valid = 1; out_code, out_id, out_skip, out_err are held stable while out_ready = 0.
  - On out_valid & out_ready: go to IDLE and clear out_valid.
  - Arbitration resumes on the next cycle. There is no same-cycle re-grant.
- Latency from accept edge to out_valid: 2 cycles for a lookup, 1 cycle for skip or err.
- Minimum issue interval: 3 cycles for a lookup, 2 cycles for skip or err.
- A requester that deasserts valid before it is granted loses nothing; inputs are sampled only on the accept edge.

Optional Feature:
- Macro: TZ_SYNC_TAB_EN.
- Defined: the table is assumed to be registered (BRAM). An extra state WAIT is inserted between accept and LOOKUP, so lookup latency becomes 3 cycles and the minimum issue interval 4. tab_addr is held for both cycles. Skip and err paths are unchanged.
- Undefined: combinational table timing as described in Behaviour.

Test Plan:
- Single lookup: req0 tc = 1, tz = 3 → req0_ready for 1 cycle; tab_addr = 0x13; out_valid 2 cycles after the accept edge; out_code = model[0x13]; out_id = 0; skip = 0; err = 0.
- Contention: both requesters valid continuously with tc = 2, tz = 1 → grants alternate 0,1,0,1 starting with 0; out_id sequence matches; the issue interval is 3 cycles when out_ready = 1.
- Skip: req1 tc = 0, then tc = 16 → out_skip = 1, out_code = 0, out_valid 1 cycle after accept; tab_addr is unchanged.
- Error: req0 tc = 14, tz = 5 (MAX_COEFF = 16) → out_err = 1, out_skip = 0, out_code = 0.
- Backpressure: out_ready held at 0 for 5 cycles in OUT → out_valid and all payload fields stay stable; both req_ready stay 0; the result completes when out_ready rises.
- Reset during LOOKUP: assert rst_n = 0 → all outputs return to 0 immediately; after release, a req1-only request is granted to req1.
